vec_issue_seq: RTL and testbench
================================

# vec_issue_seq

Parametrised decode-and-sequence stage for the vector core. It accepts one 16-bit instruction per valid/ready handshake and latches the decoded fields. It then issues element steps for the full duration of each multi-cycle op, so execute stages need no counters of their own. It sits between fetch and the vector/scalar execute units, and it replaces the purely combinational decoder with a sequencer that supports configurable vector length, configurable load latency, stall, and back-to-back issue.

## Interface
- VLEN, 16: elements per vector; power of two, ≥2
- LD_LAT, 1: extra lead cycles before the first VLD writeback; range 0..7
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  fetch offers instr
- instr  in  16  instruction word
- instr_ready  out  1  sequencer can accept this cycle
- exec_stall  in  1  execute back-pressure; freezes the sequencer
- issue_valid  out  1  an element step is issued this cycle
- step_last  out  1  final step of the current op
- elem_idx  out  $clog2(VLEN)  element index of the current step
- functype  out  4  latched opcode
- dst_addr, addr1, addr2  out  3 each  latched register addresses
- offset  out  6  latched memory offset
- immediate  out  8  latched immediate
- v_en  out  1  vector register write this step
- s_en  out  1  scalar register write this step
- illegal  out  1  undefined opcode trapped (only with the macro; otherwise tied 0)

## Operation
- Opcodes: VADD=0, VDOT=1, SMUL=2, SST=3, VLD=4, VST=5, SLL=6, SLH=7, J=8, NOP=15. Opcodes 9–14 are undefined.
- Field latching on accept. All fields not listed for an opcode are zero:
  - VADD, VDOT, SMUL: dst=[11:9], a1=[8:6], a2=[5:3].
  - VLD: dst=[11:9], a1=[8:6], off=[5:0].
  - VST, SST: a1=[8:6], a2=[11:9], off=[5:0].
  - SLL, SLH: a1=dst=[11:9], imm=[7:0].
  - J: imm=[7:0].
- States:
  - IDLE: all outputs hold the values below; instr_ready=1.
  - LEAD: VLD only; lasts LD_LAT cycles with issue_valid=0.
  - RUN: issues steps.
  - TRAP: entered only when the macro is defined.
- Step counts and write enables:
  - VADD, SMUL: VLEN steps; v_en=1 on every step.
  - VDOT: VLEN steps; s_en=1 on the last step only.
  - VST: VLEN steps; no enables.
  - VLD: LD_LAT lead cycles, then VLEN steps with v_en=1.
  - SST, J: 1 step, no enables.
  - SLL, SLH: 1 step, s_en=1.
- elem_idx counts 0..VLEN-1 across steps and is 0 for single-step ops.
- NOP is accepted in IDLE and consumed with no steps; the state stays IDLE.
- Undefined opcodes without the macro behave as NOP.
- On the last step (step_last=1 and exec_stall=0):
  - If a new instruction is accepted in that same cycle, the state goes to RUN or LEAD with zero bubble.
  - Otherwise the state goes to IDLE.

## Timing
- Reset (asynchronous): state=IDLE, counter=0, and every output except instr_ready is 0. instr_ready=1 from reset release.
- Accept occurs when instr_valid && instr_ready. The first step, or the first LEAD cycle for VLD, appears on the next cycle.
- instr_ready = (state==IDLE) || (state==RUN && step_last && !exec_stall). It is 0 in LEAD and in TRAP.
- An op of N steps with no stall occupies exactly N consecutive cycles; VLD occupies LD_LAT+VLEN.
- exec_stall=1 has these effects:
  - issue_valid, v_en and s_en are forced to 0.
  - The counter, the state and the latched fields hold.
  - The LEAD count also holds.
  - In IDLE, exec_stall has no effect.
- A stall on the last step defers both the last step and the next accept to the first unstalled cycle.
- Reset asserted mid-operation abandons the op immediately; no partial step signals remain.
- The step counter is wide enough for VLEN+LD_LAT, and its terminal compare uses full width so no wrap-around occurs.

## Configuration
- VEC_ISSUE_ILLEGAL_TRAP_EN
  - Defined:
    - An accepted opcode in 9–14 moves the state to TRAP.
    - illegal=1 from the next cycle and stays high until reset.
    - instr_ready=0 and no steps are issued while in TRAP.
  - Undefined:
    - Opcodes 9–14 are NOP.
    - illegal is tied 0.
    - TRAP does not exist.

## Structure
- Shared package vec_issue_pkg:
  - opcode localparams
  - state enum {IDLE, LEAD, RUN, TRAP}
  - packed struct for the decoded fields (functype, dst, a1, a2, offset, imm, step count, v_en-every-step, s_en-last flags)
- Sub-module vec_issue_fields: purely combinational instr-to-struct extraction. The sequencer registers its output on accept.

## Test plan
- Reset, then VADD with dst=1, a1=2, a2=3 (0x0298), VLEN=16 -> 16 consecutive issue_valid cycles; elem_idx 0..15; v_en=1 on all; step_last only at idx 15; fields hold throughout.
- VLD 0x4245 with LD_LAT=2 -> 2 cycles of issue_valid=0, then 16 steps with v_en=1; offset=5, dst=1, a1=1.
- VDOT followed immediately by SLL 0x6207 -> s_en=1 only at VDOT idx 15; the SLL step follows on the very next cycle with imm=0x07 and dst=a1=1; no bubble.
- SMUL with exec_stall=1 for 3 cycles at idx 4 -> issue_valid and v_en are 0 during the stall; idx resumes at 4; total duration 19 cycles.
- NOP, then opcode 0x9 -> no steps issued; instr_ready stays 1 without the macro. With VEC_ISSUE_ILLEGAL_TRAP_EN: illegal=1 and instr_ready=0 until reset.
- rst asserted at VST idx 7 -> all outputs 0 immediately; after release, instr_ready=1 and the next VADD starts at idx 0.

Source files
------------

// File: rtl/vec_issue_pkg.sv
// Shared opcodes, sequencer states and decoded-field bundle
// for the vector issue sequencer.
package vec_issue_pkg;

   localparam logic [3:0] OP_VADD = 4'd0;
   localparam logic [3:0] OP_VDOT = 4'd1;
   localparam logic [3:0] OP_SMUL = 4'd2;
   localparam logic [3:0] OP_SST  = 4'd3;
   localparam logic [3:0] OP_VLD  = 4'd4;
   localparam logic [3:0] OP_VST  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SLH  = 4'd7;
   localparam logic [3:0] OP_J    = 4'd8;
   localparam logic [3:0] OP_NOP  = 4'd15;

   typedef enum logic [1:0] {
      IDLE,
      LEAD,
      RUN,
      TRAP
   } state_t;

   // vec: VLEN steps (else one); v_all: v_en every step;
   // s_last: s_en on the final step
   typedef struct packed {
      logic [3:0] functype;
      logic [2:0] dst;
      logic [2:0] a1;
      logic [2:0] a2;
      logic [5:0] off;
      logic [7:0] imm;
      logic       vec;
      logic       v_all;
      logic       s_last;
   } fields_t;

endpackage

// File: rtl/vec_issue_fields.sv
// Combinational instruction-to-field extraction; fields not used
// by an opcode stay zero.
module vec_issue_fields
   import vec_issue_pkg::*;
(
   input  logic [15:0] i_instr,
   output fields_t     o_f,
   output logic        o_nop,
   output logic        o_undef
);

   always_comb begin
      o_f          = '0;
      o_f.functype = i_instr[15:12];
      o_nop        = 1'b0;
      o_undef      = 1'b0;
      unique case (i_instr[15:12])
         OP_VADD, OP_SMUL: begin
            o_f.dst   = i_instr[11:9];
            o_f.a1    = i_instr[8:6];
            o_f.a2    = i_instr[5:3];
            o_f.vec   = 1'b1;
            o_f.v_all = 1'b1;
         end
         OP_VDOT: begin
            o_f.dst    = i_instr[11:9];
            o_f.a1     = i_instr[8:6];
            o_f.a2     = i_instr[5:3];
            o_f.vec    = 1'b1;
            o_f.s_last = 1'b1;
         end
         OP_VLD: begin
            o_f.dst   = i_instr[11:9];
            o_f.a1    = i_instr[8:6];
            o_f.off   = i_instr[5:0];
            o_f.vec   = 1'b1;
            o_f.v_all = 1'b1;
         end
         OP_VST: begin
            o_f.a1  = i_instr[8:6];
            o_f.a2  = i_instr[11:9];
            o_f.off = i_instr[5:0];
            o_f.vec = 1'b1;
         end
         OP_SST: begin
            o_f.a1  = i_instr[8:6];
            o_f.a2  = i_instr[11:9];
            o_f.off = i_instr[5:0];
         end
         OP_SLL, OP_SLH: begin
            o_f.a1     = i_instr[11:9];
            o_f.dst    = i_instr[11:9];
            o_f.imm    = i_instr[7:0];
            o_f.s_last = 1'b1;
         end
         OP_J: begin
            o_f.imm = i_instr[7:0];
         end
         OP_NOP: begin
            o_nop = 1'b1;
         end
         default: begin
            o_undef = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/vec_issue_seq.sv
// Vector decode-and-sequence stage: latches fields on accept and issues
// element steps. VEC_ISSUE_ILLEGAL_TRAP_EN traps undefined opcodes.
module vec_issue_seq
   import vec_issue_pkg::*;
#(
   parameter int VLEN   = 16,
   parameter int LD_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_instr_valid,
   input  logic [15:0]             i_instr,
   output logic                    o_instr_ready,
   input  logic                    i_exec_stall,
   output logic                    o_issue_valid,
   output logic                    o_step_last,
   output logic [$clog2(VLEN)-1:0] o_elem_idx,
   output logic [3:0]              o_functype,
   output logic [2:0]              o_dst_addr,
   output logic [2:0]              o_addr1,
   output logic [2:0]              o_addr2,
   output logic [5:0]              o_offset,
   output logic [7:0]              o_immediate,
   output logic                    o_v_en,
   output logic                    o_s_en,
   output logic                    o_illegal
);

   localparam int IW = $clog2(VLEN);
   localparam int CW = $clog2(VLEN + LD_LAT + 1);
   localparam logic [CW-1:0] VEND = CW'(VLEN - 1);
   localparam logic [CW-1:0] LEND =
      (LD_LAT > 0) ? CW'(LD_LAT - 1) : '0;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   fields_t       r_f;

   fields_t w_dec;
   logic    w_nop;
   logic    w_undef;
   logic    w_run;
   logic    w_last;
   logic    w_acc;
   logic    w_skip;
   logic    w_trap;
   logic    w_hold;

   vec_issue_fields u_fields (
      .i_instr (i_instr),
      .o_f     (w_dec),
      .o_nop   (w_nop),
      .o_undef (w_undef)
   );

   assign w_run  = (r_state == RUN);
   assign w_last = w_run && (!r_f.vec || (r_cnt == VEND));
   assign w_hold = i_exec_stall && (r_state != IDLE);

   assign o_instr_ready = (r_state == IDLE) ||
                          (w_last && !i_exec_stall);
   assign w_acc = i_instr_valid && o_instr_ready;

   assign o_issue_valid = w_run && !i_exec_stall;
   assign o_step_last   = w_last;
   assign o_elem_idx    = w_run ? r_cnt[IW-1:0] : '0;
   assign o_v_en        = o_issue_valid && r_f.v_all;
   assign o_s_en        = o_issue_valid && r_f.s_last && w_last;

   assign o_functype  = r_f.functype;
   assign o_dst_addr  = r_f.dst;
   assign o_addr1     = r_f.a1;
   assign o_addr2     = r_f.a2;
   assign o_offset    = r_f.off;
   assign o_immediate = r_f.imm;

`ifdef VEC_ISSUE_ILLEGAL_TRAP_EN
   logic r_illegal;

   assign w_skip    = w_nop;
   assign w_trap    = w_undef;
   assign o_illegal = r_illegal;

   // Sticky until reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_illegal <= 1'b0;
      end else if (w_acc && w_trap) begin
         r_illegal <= 1'b1;
      end
   end
`else
   assign w_skip    = w_nop | w_undef;
   assign w_trap    = 1'b0;
   assign o_illegal = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_f     <= '0;
      end else if (!w_hold) begin
         if (w_acc) begin
            r_f   <= w_dec;
            r_cnt <= '0;
            if (w_trap) begin
               r_state <= TRAP;
            end else if (w_skip) begin
               r_state <= IDLE;
            end else if (w_dec.functype == OP_VLD && LD_LAT > 0) begin
               r_state <= LEAD;
            end else begin
               r_state <= RUN;
            end
         end else begin
            unique case (r_state)
               LEAD: begin
                  if (r_cnt == LEND) begin
                     r_state <= RUN;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               RUN: begin
                  if (w_last) begin
                     r_state <= IDLE;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vec_issue_seq.sv
// Directed self-checking bench for vec_issue_seq (VLEN=16, LD_LAT=2);
// honours VEC_ISSUE_ILLEGAL_TRAP_EN when compiled with it.
module tb_vec_issue_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ivalid = 1'b0;
   logic [15:0] instr = '0;
   logic        stall = 1'b0;

   logic       ready, issue, last, v_en, s_en, illegal;
   logic [3:0] idx, ftype;
   logic [2:0] dst, a1, a2;
   logic [5:0] off;
   logic [7:0] imm;

   int n_err = 0;
   int n_chk = 0;

   vec_issue_seq #(.VLEN(16), .LD_LAT(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_instr_valid (ivalid),
      .i_instr       (instr),
      .o_instr_ready (ready),
      .i_exec_stall  (stall),
      .o_issue_valid (issue),
      .o_step_last   (last),
      .o_elem_idx    (idx),
      .o_functype    (ftype),
      .o_dst_addr    (dst),
      .o_addr1       (a1),
      .o_addr2       (a2),
      .o_offset      (off),
      .o_immediate   (imm),
      .o_v_en        (v_en),
      .o_s_en        (s_en),
      .o_illegal     (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, {27'd0, issue, last, v_en, s_en, illegal}, 32'd0);
      check({tag, "_idx"}, {28'd0, idx}, 32'd0);
      check({tag, "_fld"}, {5'd0, ftype, dst, a1, a2, off, imm}, 32'd0);
      check({tag, "_rdy"}, {31'd0, ready}, 32'd1);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ctl"}, {28'd0, issue, last, v_en, s_en}, 32'd0);
      check({tag, "_rdy"}, {31'd0, ready}, 32'd1);
   endtask

   int exp_idx;
   logic exp_stall;

   initial begin
      // reset state
      @(negedge clk); #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // VADD dst=1 a1=2 a2=3
      @(negedge clk);
      ivalid = 1'b1; instr = 16'h0298; #1;
      check("vadd_acc_rdy", {31'd0, ready}, 32'd1);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         ivalid = 1'b0; instr = '0; #1;
         check("vadd_issue", {30'd0, issue, v_en}, 32'd3);
         check("vadd_idx", {28'd0, idx}, i);
         check("vadd_last", {31'd0, last}, (i == 15) ? 32'd1 : 32'd0);
         check("vadd_fld", {19'd0, ftype, dst, a1, a2}, {19'd0, 4'd0, 3'd1, 3'd2, 3'd3});
      end
      @(negedge clk); #1;
      check_idle("vadd_end");

      // VLD dst=1 a1=1 off=5, two lead cycles
      @(negedge clk);
      ivalid = 1'b1; instr = 16'h4245; #1;
      for (int l = 0; l < 2; l++) begin
         @(negedge clk);
         ivalid = 1'b0; instr = '0; #1;
         check("vld_lead", {29'd0, issue, v_en, ready}, 32'd0);
      end
      for (int i = 0; i < 16; i++) begin
         @(negedge clk); #1;
         check("vld_issue", {30'd0, issue, v_en}, 32'd3);
         check("vld_idx", {28'd0, idx}, i);
         if (i == 0 || i == 15)
            check("vld_fld", {13'd0, ftype, dst, a1, a2, off},
                  {13'd0, 4'd4, 3'd1, 3'd1, 3'd0, 6'd5});
      end
      @(negedge clk); #1;
      check_idle("vld_end");

      // VDOT then SLL back to back
      @(negedge clk);
      ivalid = 1'b1; instr = 16'h1298; #1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         ivalid = (i == 15);
         instr = (i == 15) ? 16'h6207 : 16'h0000; #1;
         check("vdot_en", {30'd0, v_en, s_en}, (i == 15) ? 32'd1 : 32'd0);
         check("vdot_idx", {28'd0, idx}, i);
         check("vdot_rdy", {31'd0, ready}, (i == 15) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      ivalid = 1'b0; instr = '0; #1;
      check("sll_ctl", {28'd0, issue, last, v_en, s_en}, 32'b1101);
      check("sll_idx", {28'd0, idx}, 32'd0);
      check("sll_fld", {14'd0, ftype, dst, a1, imm},
            {14'd0, 4'd6, 3'd1, 3'd1, 8'h07});
      @(negedge clk); #1;
      check_idle("sll_end");

      // SMUL with a 3-cycle stall at idx 4
      @(negedge clk);
      ivalid = 1'b1; instr = 16'h2298; #1;
      for (int c = 0; c < 19; c++) begin
         @(negedge clk);
         ivalid = 1'b0; instr = '0;
         exp_stall = (c >= 4 && c <= 6);
         exp_idx = (c < 4) ? c : (c < 7) ? 4 : c - 3;
         stall = exp_stall; #1;
         check("smul_issue", {30'd0, issue, v_en},
               exp_stall ? 32'd0 : 32'd3);
         check("smul_idx", {28'd0, idx}, exp_idx);
         check("smul_last", {31'd0, last}, (exp_idx == 15) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      stall = 1'b0; #1;
      check_idle("smul_end");

      // SST: stall on its single (last) step
      @(negedge clk);
      ivalid = 1'b1; instr = 16'h3A05; #1;
      @(negedge clk);
      ivalid = 1'b1; instr = 16'h0298; stall = 1'b1; #1;
      check("sst_stall", {29'd0, issue, last, ready}, 32'b010);
      @(negedge clk);
      ivalid = 1'b0; instr = '0; stall = 1'b0; #1;
      check("sst_step", {28'd0, issue, last, ready, s_en}, 32'b1110);
      check("sst_fld", {12'd0, ftype, dst, a1, a2, off},
            {12'd0, 4'd3, 3'd0, 3'd0, 3'd5, 6'd5});
      @(negedge clk);
      stall = 1'b1; #1;
      check_idle("idle_stall");
      @(negedge clk);
      stall = 1'b0;

      // NOP then undefined opcode 9
      @(negedge clk);
      ivalid = 1'b1; instr = 16'hF000; #1;
      @(negedge clk);
      ivalid = 1'b1; instr = 16'h9000; #1;
      check_idle("nop_end");
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         ivalid = 1'b0; instr = '0; #1;
         check("op9_issue", {31'd0, issue}, 32'd0);
`ifdef VEC_ISSUE_ILLEGAL_TRAP_EN
         check("op9_trap", {30'd0, illegal, ready}, 32'b10);
`else
         check("op9_trap", {30'd0, illegal, ready}, 32'b01);
`endif
      end
      @(negedge clk);
      rst = 1'b1; #1;
      check_zero("rst2");
      @(negedge clk);
      rst = 1'b0;

      // VST aborted by reset at idx 7
      @(negedge clk);
      ivalid = 1'b1; instr = 16'h5A05; #1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ivalid = 1'b0; instr = '0; #1;
         check("vst_issue", {29'd0, issue, v_en, s_en}, 32'b100);
         check("vst_idx", {28'd0, idx}, i);
      end
      #2 rst = 1'b1; #1;
      check_zero("vst_rst");
      @(negedge clk);
      rst = 1'b0;
      ivalid = 1'b1; instr = 16'h0298; #1;
      check("post_rst_rdy", {31'd0, ready}, 32'd1);
      @(negedge clk);
      ivalid = 1'b0; instr = '0; #1;
      check("post_rst_step", {30'd0, issue, v_en}, 32'd3);
      check("post_rst_idx", {28'd0, idx}, 32'd0);
      check("post_rst_fld", {23'd0, dst, a1, a2}, {23'd0, 3'd1, 3'd2, 3'd3});

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
